// File: rtl/eq_gain_ctrl_pkg.sv
// Shared types and constants for the equalizer
// gain controller and the equalizer top.
package eq_ctrl_pkg;

  localparam int NUM_BAND     = 3;
  localparam int GAIN_W       = 3;
  localparam int DEFAULT_GAIN = 4;
  localparam int BAND_W       = $clog2(NUM_BAND);

  typedef logic [GAIN_W-1:0] gain_t;
  typedef logic [BAND_W-1:0] band_t;
  typedef gain_t [NUM_BAND-1:0] gain_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    STEP
  } state_e;

  function automatic gain_t step_toward(
    input gain_t cur,
    input gain_t tgt
  );
    gain_t nxt;
    nxt = cur;
    if (cur < tgt) nxt = cur + 1'b1;
    else if (cur > tgt) nxt = cur - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/eq_gain_ctrl_if.sv
// Request and gain bundle between the key logic,
// the gain controller and the equalizer.
interface eq_gain_ctrl_if;
  import eq_ctrl_pkg::*;

  logic      en_i;
  logic      sample_tick_i;
  logic      next_band_i;
  logic      inc_i;
  logic      dec_i;
  logic      reset_gains_i;
  band_t     band_sel_o;
  gain_vec_t target_o;
  gain_vec_t gain_o;
  logic      commit_o;
  logic      busy_o;

  modport master (
    output en_i,
    output sample_tick_i,
    output next_band_i,
    output inc_i,
    output dec_i,
    output reset_gains_i,
    input  band_sel_o,
    input  target_o,
    input  gain_o,
    input  commit_o,
    input  busy_o
  );

  modport slave (
    input  en_i,
    input  sample_tick_i,
    input  next_band_i,
    input  inc_i,
    input  dec_i,
    input  reset_gains_i,
    output band_sel_o,
    output target_o,
    output gain_o,
    output commit_o,
    output busy_o
  );

endinterface

// File: rtl/eq_ramp_timer.sv
// Sample-tick interval counter with clear, count
// enable and a terminal-count pulse.
module eq_ramp_timer #(
  parameter int COUNT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tc_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/eq_gain_ctrl.sv
// Per-band target gains from user requests, with
// tick-paced one-LSB ramping of the applied gains.
module eq_gain_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int RAMP_SAMPLES = 16
) (
  input logic clk_i,
  input logic rst_ni,
  eq_gain_ctrl_if.slave bus
);

  localparam gain_t GMAX  = gain_t'((1 << GAIN_W) - 1);
  localparam gain_t GDEF  = gain_t'(DEFAULT_GAIN);
  localparam band_t BLAST = band_t'(NUM_BAND - 1);

  gain_vec_t tgt_q, tgt_d;
  gain_vec_t gain_q, gain_d;
  gain_vec_t gain_nx;
  band_t     band_q, band_d;
  state_e    state_q, state_d;
  logic      commit_q, commit_d;
  logic      busy_q, busy_d;
  logic      tick;
  logic      tmr_clr;
  logic      tc;
  logic      mis_now;
  logic      mis_nx;

  always_comb begin
    tgt_d  = tgt_q;
    band_d = band_q;
    if (bus.en_i) begin
      if (bus.reset_gains_i) begin
        tgt_d  = {NUM_BAND{GDEF}};
        band_d = '0;
      end else if (bus.next_band_i) begin
        band_d = (band_q == BLAST) ? '0
                                   : band_q + 1'b1;
      end else if (bus.inc_i && !bus.dec_i) begin
        if (tgt_q[band_q] != GMAX)
          tgt_d[band_q] = tgt_q[band_q] + 1'b1;
      end else if (bus.dec_i && !bus.inc_i) begin
        if (tgt_q[band_q] != '0)
          tgt_d[band_q] = tgt_q[band_q] - 1'b1;
      end
    end
  end

  always_comb begin
    gain_nx = gain_q;
    for (int b = 0; b < NUM_BAND; b++)
      gain_nx[b] = step_toward(gain_q[b], tgt_q[b]);
  end

  assign mis_now = (gain_q != tgt_q);
  assign mis_nx  = (gain_nx != tgt_q);
  assign tick    = bus.en_i & bus.sample_tick_i;

  eq_ramp_timer #(
    .COUNT (RAMP_SAMPLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (tmr_clr),
    .en_i   (tick),
    .tc_o   (tc)
  );

  // Ramp always chases the live target; a
  // retarget never restarts the interval count.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    commit_d = 1'b0;
    tmr_clr  = 1'b0;
    if (bus.en_i) begin
      unique case (state_q)
        IDLE: begin
          tmr_clr = 1'b1;
          if (mis_now) state_d = RAMP;
        end
        RAMP: begin
          if (!mis_now) state_d = IDLE;
          else if (tc)  state_d = STEP;
        end
        STEP: begin
          gain_d   = gain_nx;
          commit_d = mis_now;
          state_d  = mis_nx ? RAMP : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tgt_q    <= {NUM_BAND{GDEF}};
      gain_q   <= {NUM_BAND{GDEF}};
      band_q   <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      gain_q   <= gain_d;
      band_q   <= band_d;
      commit_q <= commit_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.band_sel_o = band_q;
  assign bus.target_o   = tgt_q;
  assign bus.gain_o     = gain_q;
  assign bus.commit_o   = commit_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Scoreboard bench for eq_gain_ctrl: directed plan
// followed by a randomized request/tick phase.
module tb_eq_gain_ctrl;
  import eq_ctrl_pkg::*;

  localparam int RS   = 4;
  localparam int GTOP = (1 << GAIN_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eq_gain_ctrl_if bus();

  eq_gain_ctrl #(
    .RAMP_SAMPLES (RS)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int ncommit = 0;

  int m_tgt[NUM_BAND];
  int m_gain[NUM_BAND];
  int m_band;
  int m_cnt;
  bit m_active;
  bit m_due;
  gain_vec_t exp_q[$];

  function automatic gain_vec_t pk(input int a[NUM_BAND]);
    gain_vec_t v;
    for (int b = 0; b < NUM_BAND; b++) v[b] = gain_t'(a[b]);
    return v;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NUM_BAND; b++) begin
      m_tgt[b]  = DEFAULT_GAIN;
      m_gain[b] = DEFAULT_GAIN;
    end
    m_band   = 0;
    m_cnt    = 0;
    m_active = 0;
    m_due    = 0;
    exp_q.delete();
  endtask

  // Reference behaviour for one clock edge, computed
  // from the pre-edge view of targets and gains.
  task automatic model(input bit en, tk, nb, in, de, rg);
    int ng[NUM_BAND];
    if (!en) return;
    ng = m_gain;
    if (m_due) begin
      for (int b = 0; b < NUM_BAND; b++) begin
        if (m_gain[b] < m_tgt[b]) ng[b] = m_gain[b] + 1;
        if (m_gain[b] > m_tgt[b]) ng[b] = m_gain[b] - 1;
      end
      if (pk(ng) != pk(m_gain)) exp_q.push_back(pk(ng));
      m_due    = 0;
      m_cnt    = tk ? 1 : 0;
      m_active = (pk(ng) != pk(m_tgt));
    end else if (m_active) begin
      if (pk(m_gain) == pk(m_tgt)) begin
        m_active = 0;
      end else if (tk) begin
        m_cnt++;
        if (m_cnt == RS) begin
          m_cnt = 0;
          m_due = 1;
        end
      end
    end else if (pk(m_gain) != pk(m_tgt)) begin
      m_active = 1;
      m_cnt    = 0;
    end
    m_gain = ng;
    if (rg) begin
      for (int b = 0; b < NUM_BAND; b++)
        m_tgt[b] = DEFAULT_GAIN;
      m_band = 0;
    end else if (nb) begin
      m_band = (m_band + 1) % NUM_BAND;
    end else if (in && !de) begin
      if (m_tgt[m_band] < GTOP) m_tgt[m_band]++;
    end else if (de && !in) begin
      if (m_tgt[m_band] > 0) m_tgt[m_band]--;
    end
  endtask

  task automatic check_state();
    chk("target", int'(bus.target_o), int'(pk(m_tgt)));
    chk("gain", int'(bus.gain_o), int'(pk(m_gain)));
    chk("band_sel", int'(bus.band_sel_o), m_band);
    chk("busy", int'(bus.busy_o), int'(m_active | m_due));
  endtask

  task automatic clk1(input bit en, tk, nb, in, de, rg);
    bus.en_i          = en;
    bus.sample_tick_i = tk;
    bus.next_band_i   = nb;
    bus.inc_i         = in;
    bus.dec_i         = de;
    bus.reset_gains_i = rg;
    model(en, tk, nb, in, de, rg);
    @(negedge clk);
    #1;
    check_state();
  endtask

  task automatic req(input bit nb, in, de, rg);
    clk1(1, 0, nb, in, de, rg);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((m_active || m_due ||
            pk(m_gain) != pk(m_tgt)) && n < 300) begin
      clk1(1, 1, 0, 0, 0, 0);
      n++;
    end
    chk({nm, "_settle_in_budget"}, int'(n < 300), 1);
  endtask

  task automatic wait_commit(input string nm);
    int n  = 0;
    int c0 = ncommit;
    while (ncommit == c0 && n < 100) begin
      clk1(1, 1, 0, 0, 0, 0);
      n++;
    end
    chk({nm, "_commit_in_budget"}, int'(n < 100), 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.commit_o) begin
      ncommit++;
      if (exp_q.size() == 0)
        chk("commit_unexpected", int'(bus.commit_o), 0);
      else
        chk("commit_gain", int'(bus.gain_o),
            int'(exp_q.pop_front()));
    end
  end

  initial begin
    int c0;
    gain_vec_t gfrz;
    rst_n             = 1'b0;
    bus.en_i          = 1'b0;
    bus.sample_tick_i = 1'b0;
    bus.next_band_i   = 1'b0;
    bus.inc_i         = 1'b0;
    bus.dec_i         = 1'b0;
    bus.reset_gains_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gain", int'(bus.gain_o), 'o444);
    chk("rst_target", int'(bus.target_o), 'o444);
    chk("rst_busy", int'(bus.busy_o), 0);
    rst_n = 1'b1;
    repeat (20) clk1(1, 1, 0, 0, 0, 0);
    chk("idle_commits", ncommit, 0);

    c0 = ncommit;
    req(0, 1, 0, 0);
    req(0, 1, 0, 0);
    chk("inc2_target0", int'(bus.target_o[0]), 6);
    wait_commit("inc2_first");
    chk("inc2_gain0_mid", int'(bus.gain_o[0]), 5);
    wait_idle("inc2");
    chk("inc2_gain0", int'(bus.gain_o[0]), 6);
    chk("inc2_commits", ncommit - c0, 2);
    chk("inc2_gain1", int'(bus.gain_o[1]), 4);

    req(1, 0, 0, 0);
    repeat (5) req(0, 1, 0, 0);
    chk("sat_hi_target1", int'(bus.target_o[1]), 7);
    c0 = ncommit;
    wait_idle("sat_hi");
    chk("sat_hi_gain1", int'(bus.gain_o[1]), 7);
    chk("sat_hi_commits", ncommit - c0, 3);

    req(0, 0, 0, 1);
    wait_idle("restore");
    c0 = ncommit;
    repeat (5) req(0, 0, 1, 0);
    chk("sat_lo_target0", int'(bus.target_o[0]), 0);
    wait_idle("sat_lo");
    chk("sat_lo_gain0", int'(bus.gain_o[0]), 0);
    chk("sat_lo_commits", ncommit - c0, 4);

    req(0, 1, 1, 0);
    chk("incdec_target0", int'(bus.target_o[0]), 0);
    req(1, 0, 0, 0);
    req(1, 0, 0, 1);
    chk("rg_nb_band", int'(bus.band_sel_o), 0);
    chk("rg_nb_target", int'(bus.target_o), 'o444);
    req(1, 0, 0, 0);
    chk("nb_seq1", int'(bus.band_sel_o), 1);
    req(1, 0, 0, 0);
    chk("nb_seq2", int'(bus.band_sel_o), 2);
    req(1, 0, 0, 0);
    chk("nb_seq0", int'(bus.band_sel_o), 0);
    wait_idle("conflicts");

    req(1, 0, 0, 0);
    req(1, 0, 0, 0);
    repeat (3) req(0, 1, 0, 0);
    c0 = ncommit;
    wait_commit("retarget");
    chk("retarget_gain2_mid", int'(bus.gain_o[2]), 5);
    req(0, 0, 1, 0);
    req(0, 0, 1, 0);
    wait_idle("retarget");
    repeat (12) clk1(1, 1, 0, 0, 0, 0);
    chk("retarget_gain2", int'(bus.gain_o[2]), 5);
    chk("retarget_commits", ncommit - c0, 1);

    c0 = ncommit;
    req(0, 1, 0, 0);
    req(0, 1, 0, 0);
    repeat (2) clk1(1, 1, 0, 0, 0, 0);
    gfrz = pk(m_gain);
    repeat (10) clk1(0, 1, 1, 1, 0, 0);
    chk("en_low_gain", int'(bus.gain_o), int'(gfrz));
    chk("en_low_commits", ncommit - c0, 0);
    wait_idle("en_resume");
    chk("en_gain2", int'(bus.gain_o[2]), 7);
    chk("en_commits", ncommit - c0, 2);

    req(0, 0, 0, 1);
    repeat (3) clk1(1, 1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gain", int'(bus.gain_o), 'o444);
    chk("arst_target", int'(bus.target_o), 'o444);
    chk("arst_busy", int'(bus.busy_o), 0);
    chk("arst_commit", int'(bus.commit_o), 0);
    chk("arst_band", int'(bus.band_sel_o), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 600; i++) begin
      clk1($urandom_range(0, 9) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0);
    end
    wait_idle("random");
    repeat (2) clk1(1, 1, 0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/eq_gain_ctrl.md
# eq_gain_ctrl

Controller that owns the per-band gain selection of the audio equalizer. It turns single-cycle user requests (band select, gain up/down, restore defaults) into saturated per-band target gains. It ramps the applied gains toward those targets one LSB at a time, paced by the audio sample tick, so band changes take effect without zipper noise. It sits between the key/edge-detect logic and the equalizer's band-gain inputs, and replaces direct key-to-gain wiring.

## Interface
- NUM_BAND, 3, number of equalizer bands
- GAIN_W, 3, gain code width; legal codes 0..2^GAIN_W-1
- DEFAULT_GAIN, 4, gain code loaded at reset and on reset_gains_i
- RAMP_SAMPLES, 16, sample ticks between successive ramp steps (>=1)

- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- en_i  in  1  block enable; low = requests ignored, ramp frozen
- sample_tick_i  in  1  one-cycle pulse per audio sample, already in clk_i domain
- next_band_i  in  1  one-cycle request: advance selected band
- inc_i / dec_i  in  1 each  one-cycle request: target of selected band +1 / -1
- reset_gains_i  in  1  one-cycle request: all targets to DEFAULT_GAIN, band_sel to 0
- band_sel_o  out  $clog2(NUM_BAND)  currently selected band
- target_o  out  NUM_BAND x GAIN_W  target gains (for display)
- gain_o  out  NUM_BAND x GAIN_W  applied gains, drives equalizer band selects
- commit_o  out  1  one-cycle pulse coincident with any gain_o change
- busy_o  out  1  high while state != IDLE

## Operation
- Reset: gain_o = target_o = DEFAULT_GAIN for every band, band_sel_o = 0, commit_o = 0, busy_o = 0, state IDLE, tick counter 0.
- Request priority in one cycle (en_i high): reset_gains_i > next_band_i > inc_i/dec_i. Lower-priority requests in the same cycle are dropped.
- inc_i and dec_i together: no change.
- inc saturates at 2^GAIN_W-1. dec saturates at 0. No wrap.
- next_band_i: band_sel_o wraps NUM_BAND-1 -> 0.
- Targets may change at any time, including during a ramp. The ramp always chases the current target and does not restart the tick counter.
- FSM:
  - IDLE: if any gain_o[b] != target_o[b], go to RAMP with cnt = 0.
  - RAMP: each sample_tick_i increments cnt. The tick that makes cnt reach RAMP_SAMPLES sends the FSM to STEP, cnt = 0. If all bands match again (target moved back), return to IDLE.
  - STEP, one cycle: every mismatched band moves one LSB toward its target, all bands simultaneously. commit_o fires. Next state is RAMP if any band is still mismatched after the step, else IDLE. A sample_tick_i during STEP counts toward the next interval (cnt = 1).
- en_i low: requests ignored, sample ticks ignored, state/cnt/gains held, commit_o = 0.
- Asynchronous reset mid-ramp: all outputs return to reset values immediately.

## Timing
- Request at cycle n: target_o / band_sel_o updated at n+1.
- First IDLE->RAMP at n+2.
- gain_o and commit_o are registered. They change in the cycle after STEP, and commit_o is high for exactly that one cycle.
- A distance of d codes needs d steps. Each step follows RAMP_SAMPLES counted ticks, plus a one-cycle STEP.
- busy_o falls the cycle after the final STEP.
- All outputs are registered. No combinational input-to-output path.

## Structure
- Package eq_ctrl_pkg:
  - state enum {IDLE, RAMP, STEP}
  - gain_t typedef (logic [GAIN_W-1:0])
  - NUM_BAND and DEFAULT_GAIN constants, shared with the equalizer top.
- One sub-module, eq_ramp_timer: sample-tick counter with clear, enable and terminal-count pulse.
- Target registers, band select and FSM stay in eq_gain_ctrl.

## Test plan
- Reset and release, RAMP_SAMPLES=4 (used throughout) -> all gain_o = target_o = 4, band_sel_o = 0, busy_o = 0, commit_o never pulses.
- Two inc_i pulses on band 0 -> target_o[0] = 6 at n+2. After 4 ticks gain_o[0] = 5 with one commit_o pulse. After 4 more ticks gain_o[0] = 6, then busy_o = 0. Other bands stay 4.
- Saturation:
  - next_band once, then five inc_i -> target_o[1] = 7.
  - reset_gains_i, then five dec_i on band 0 -> target 0.
  - The ramp ends at 7 / 0 with exactly 3 / 4 commits.
- Same-cycle conflicts:
  - inc_i+dec_i -> no change.
  - reset_gains_i+next_band_i -> targets 4, band_sel_o = 0.
  - Three next_band_i pulses from band 0 -> band_sel_o sequence 1, 2, 0.
- Retarget mid-ramp: band 2 target 4->7, then after one step set back to 5 -> gain_o[2] goes 5 and stops, with no extra commit.
- en_i low for 10 ticks mid-ramp -> gain_o and commit_o frozen, resumes with the remaining count. Assert rst_ni mid-ramp -> outputs at reset values in the same cycle.
